pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
Sequencer for the program counter and the branch/jump target datapath of the single-issue core. It owns the PC register and runs the fetch handshake with instruction memory. Once the control unit commits an instruction, it selects the next PC from pc+4, the jal/jalr/branch targets produced by the target-generation block, mtvec, or mepc. It also resolves branch conditions and raises misaligned-target traps and interrupt redirects.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
MISALIGN_CHK, 1, 1 = trap on target[1:0]!=0; 0 = no check, target used as-is

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  32  current PC; also the imem address
imem_req  out  1  fetch request, held until acked
imem_ack  in  1  imem accepted request; instruction valid this cycle
ir_valid  out  1  one-cycle pulse: fetched instruction latched, decode may start
commit  in  1  control unit commits current instruction; next_sel valid
next_sel  in  3  0 PLUS4, 1 JAL, 2 JALR, 3 BRANCH, 4 MRET; 5-7 treated as PLUS4
funct3  in  3  branch type: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
br_eq, br_lt, br_ltu  in  1 each  comparator flags for rs1 vs rs2
jal_tgt, jalr_tgt, branch_tgt  in  32 each  targets from target-generation block
mtvec, mepc  in  32 each  CSR values
intr_pend, intr_en  in  1 each  pending interrupt; global enable
mepc_we  out  1  one-cycle pulse: write mepc_val into mepc
mepc_val  out  32  value for mepc
trap_misalign  out  1  one-cycle pulse on misaligned-target trap
taken  out  1  one-cycle pulse: redirect other than PLUS4 took effect

Behaviour:
- Reset (async, any state): pc=RESET_VEC; state=IDLE; imem_req, ir_valid, mepc_we, trap_misalign, taken=0; mepc_val=0.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: first clock after rst_n release, go to FETCH.
- FETCH: imem_req=1 and pc held stable until imem_ack=1. On ack, go to EXEC; ir_valid=1 for exactly the next cycle.
- EXEC: imem_req=0. Wait for commit; commit outside EXEC is ignored. On commit, compute the target, update pc at that edge, and go to FETCH.
- Minimum throughput: 2 cycles per instruction (ack in the first FETCH cycle, commit in the first EXEC cycle).
- Target selection:
  - PLUS4: pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - JAL: jal_tgt.
  - JALR: {jalr_tgt[31:1],1'b0}.
  - BRANCH: branch_tgt if the condition holds, else pc+4. Conditions: beq=br_eq, bne=!br_eq, blt=br_lt, bge=!br_lt, bltu=br_ltu, bgeu=!br_ltu. Undefined funct3 means not taken.
  - MRET: mepc.
- Priority at commit, highest first:
  1. Misaligned target (MISALIGN_CHK=1, chosen target bit1 set): pc=mtvec, mepc_val=pc of faulting instruction, mepc_we=1, trap_misalign=1. A not-taken branch is never misaligned. A pending interrupt stays pending.
  2. Interrupt (intr_pend and intr_en, next_sel!=MRET): pc=mtvec, mepc_val=computed target, mepc_we=1. The committed instruction completes; its effect is the saved return address.
  3. Normal: pc=target; taken=1 if target != pc+4 path (jumps, taken branches, MRET).
- All pulses (ir_valid, mepc_we, trap_misalign, taken) are registered, high for one cycle, and mutually consistent with the pc update edge.
- mepc_val holds its last value when mepc_we=0.
- imem_ack outside FETCH is ignored.
- Reset asserted mid-FETCH drops imem_req asynchronously. A late ack after reset is ignored, because the state is IDLE.

Decomposition:
- Shared package core_pkg holds:
  - the next_sel enum (PLUS4, JAL, JALR, BRANCH, MRET);
  - the funct3 branch encodings;
  - the FSM state enum;
  - RESET_VEC default.
- One sub-module, branch_cond_eval, is natural: combinational funct3 + flags to taken. It is reusable by the control unit.

Test Plan:
- Reset release, RESET_VEC=0, ack in the first FETCH cycle, commit PLUS4 x3 → pc sequence 0,4,8,12; ir_valid once per instruction; 2 cycles/instruction.
- pc=0x100, BRANCH funct3=001, br_eq=0, branch_tgt=0x80 → pc=0x80, taken=1. Repeat with br_eq=1 → pc=0x104, taken=0.
- pc=0x200, JALR, jalr_tgt=0x301 → pc=0x300. JAL with jal_tgt=0x402 → pc=mtvec=0x1000, trap_misalign=1, mepc_we=1, mepc_val=0x200.
- pc=0x40, commit PLUS4 with intr_pend=1, intr_en=1, mtvec=0x1000 → pc=0x1000, mepc_val=0x44. Then MRET with mepc=0x44 and intr_pend still 1 → pc=0x44, no re-trap on the MRET commit.
- imem_ack held low 5 cycles → imem_req stays high and pc stable. rst_n pulsed low mid-wait → imem_req drops immediately, pc=RESET_VEC, then refetch from RESET_VEC.
- pc=0xFFFF_FFFC, commit PLUS4 → pc=0x0000_0000, taken=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the core front-end: next-PC selects, branch funct3 codes,
// and the fetch/execute sequencer states.
package core_pkg;

  typedef enum logic [2:0] {
    SEL_PLUS4  = 3'd0,
    SEL_JAL    = 3'd1,
    SEL_JALR   = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_MRET   = 3'd4
  } next_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition resolver: funct3 plus comparator flags to a taken decision.
// Undefined funct3 encodings resolve to not taken.
module branch_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = br_eq;
      F3_BNE:  br_taken = !br_eq;
      F3_BLT:  br_taken = br_lt;
      F3_BGE:  br_taken = !br_lt;
      F3_BLTU: br_taken = br_ltu;
      F3_BGEU: br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC owner and fetch/commit sequencer: runs the imem handshake and picks the
// next PC from pc+4, jump/branch targets, mtvec or mepc at commit.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | out of reset, one cycle before the first fetch
//   ST_FETCH | imem_req high, pc held until imem_ack
//   ST_EXEC  | instruction latched, waiting for commit to redirect pc
module pc_redirect_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC    = RESET_VEC_DEFAULT,
  parameter bit          MISALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_valid,
  input  logic        commit,
  input  logic [2:0]  next_sel,
  input  logic [2:0]  funct3,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] branch_tgt,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        intr_pend,
  input  logic        intr_en,
  output logic        mepc_we,
  output logic [31:0] mepc_val,
  output logic        trap_misalign,
  output logic        taken
);

  pc_state_e   state_q, state_d;
  next_sel_e   sel;
  logic        br_taken;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        redirect;
  logic        misalign;
  logic        intr_take;
  logic        fetch_done;
  logic        commit_fire;

  branch_cond_eval u_branch_cond_eval (
    .funct3   (funct3),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .br_ltu   (br_ltu),
    .br_taken (br_taken)
  );

  assign fetch_done  = (state_q == ST_FETCH) && imem_ack;
  assign commit_fire = (state_q == ST_EXEC) && commit;
  // Decoded from the state register so reset drops the request asynchronously.
  assign imem_req    = (state_q == ST_FETCH);
  assign pc_plus4    = pc + 32'd4;

  always_comb begin
    sel = SEL_PLUS4;
    case (next_sel)
      SEL_JAL:    sel = SEL_JAL;
      SEL_JALR:   sel = SEL_JALR;
      SEL_BRANCH: sel = SEL_BRANCH;
      SEL_MRET:   sel = SEL_MRET;
      default:    sel = SEL_PLUS4;
    endcase
  end

  always_comb begin
    tgt      = pc_plus4;
    redirect = 1'b0;
    case (sel)
      SEL_JAL: begin
        tgt      = jal_tgt;
        redirect = 1'b1;
      end
      SEL_JALR: begin
        tgt      = jalr_tgt & ~32'd1;
        redirect = 1'b1;
      end
      SEL_BRANCH: begin
        tgt      = br_taken ? branch_tgt : pc_plus4;
        redirect = br_taken;
      end
      SEL_MRET: begin
        tgt      = mepc;
        redirect = 1'b1;
      end
      default: begin
        tgt      = pc_plus4;
        redirect = 1'b0;
      end
    endcase
  end

  // Only real redirects are checked, so a not-taken branch can never trap.
  assign misalign  = MISALIGN_CHK && redirect && (tgt[1:0] != 2'b00);
  assign intr_take = intr_pend && intr_en && (sel != SEL_MRET);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  if (commit) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VEC;
      ir_valid      <= 1'b0;
      mepc_we       <= 1'b0;
      mepc_val      <= 32'd0;
      trap_misalign <= 1'b0;
      taken         <= 1'b0;
    end else begin
      ir_valid      <= fetch_done;
      mepc_we       <= 1'b0;
      trap_misalign <= 1'b0;
      taken         <= 1'b0;
      if (commit_fire) begin
        if (misalign) begin
          pc            <= mtvec;
          mepc_val      <= pc;
          mepc_we       <= 1'b1;
          trap_misalign <= 1'b1;
        end else if (intr_take) begin
          // The committed instruction retires; its next PC becomes the return address.
          pc       <= mtvec;
          mepc_val <= tgt;
          mepc_we  <= 1'b1;
        end else begin
          pc    <= tgt;
          taken <= redirect;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scenario bench for pc_redirect_ctrl: per-instruction expectations are queued
// when commit is driven and compared once the pc update edge has passed.
module tb_pc_redirect_ctrl;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        taken;
    logic        we;
    logic        trap;
    logic [31:0] mval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        ir_valid;
  logic        commit = 1'b0;
  logic [2:0]  next_sel = 3'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic [31:0] jal_tgt = 32'h0, jalr_tgt = 32'h0, branch_tgt = 32'h0;
  logic [31:0] mtvec = 32'h0000_1000;
  logic [31:0] mepc = 32'h0;
  logic        intr_pend = 1'b0, intr_en = 1'b0;
  logic        mepc_we;
  logic [31:0] mepc_val;
  logic        trap_misalign;
  logic        taken;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  pc_redirect_ctrl #(.RESET_VEC(32'h0000_0000), .MISALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_valid(ir_valid), .commit(commit), .next_sel(next_sel), .funct3(funct3),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .jal_tgt(jal_tgt),
    .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt), .mtvec(mtvec), .mepc(mepc),
    .intr_pend(intr_pend), .intr_en(intr_en), .mepc_we(mepc_we),
    .mepc_val(mepc_val), .trap_misalign(trap_misalign), .taken(taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; returns at the first negedge where imem_req is high.
  task automatic wait_fetch(input string nm);
    for (int i = 0; i < 10; i++) begin
      if (imem_req === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s: imem_req never rose (got %b, want 1)", nm, imem_req);
  endtask

  task automatic do_instr(input string nm, input logic [2:0] sel, input logic [2:0] f3,
                          input logic eq, input logic lt, input logic ltu,
                          input logic [31:0] tgt, input logic ip, input logic ie,
                          input logic [31:0] mepc_in, input logic [31:0] e_pc,
                          input logic e_taken, input logic e_we, input logic e_trap,
                          input logic [31:0] e_mval);
    exp_t e;
    wait_fetch(nm);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({ir_valid, imem_req, taken, mepc_we, trap_misalign} !== 5'b10000) begin
      errors++;
      $display("FAIL %s exec_entry: {ir_valid,req,taken,we,trap}=%b want 10000", nm,
               {ir_valid, imem_req, taken, mepc_we, trap_misalign});
    end
    next_sel   = sel;
    funct3     = f3;
    br_eq      = eq;
    br_lt      = lt;
    br_ltu     = ltu;
    jal_tgt    = 32'h0000_0A00;
    jalr_tgt   = 32'h0000_0B00;
    branch_tgt = 32'h0000_0C00;
    case (sel)
      3'd1:    jal_tgt = tgt;
      3'd2:    jalr_tgt = tgt;
      3'd3:    branch_tgt = tgt;
      default: ;
    endcase
    intr_pend = ip;
    intr_en   = ie;
    mepc      = mepc_in;
    commit    = 1'b1;
    e = '{nm, e_pc, e_taken, e_we, e_trap, e_mval};
    sb.push_back(e);
    @(negedge clk);
    commit = 1'b0;
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc);
    end
    checks++;
    if ({taken, mepc_we, trap_misalign} !== {e.taken, e.we, e.trap}) begin
      errors++;
      $display("FAIL %s pulses {taken,we,trap}: got %b want %b", e.name,
               {taken, mepc_we, trap_misalign}, {e.taken, e.we, e.trap});
    end
    checks++;
    if (mepc_val !== e.mval) begin
      errors++;
      $display("FAIL %s mepc_val: got %h want %h", e.name, mepc_val, e.mval);
    end
    checks++;
    if ({ir_valid, imem_req} !== 2'b01) begin
      errors++;
      $display("FAIL %s refetch {ir_valid,req}: got %b want 01", e.name, {ir_valid, imem_req});
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pc, imem_req, ir_valid, mepc_we, trap_misalign, taken, mepc_val} !== {32'h0, 5'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: pc=%h req=%b irv=%b we=%b trap=%b taken=%b mval=%h want all 0",
               pc, imem_req, ir_valid, mepc_we, trap_misalign, taken, mepc_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_fetch: imem_req=%b want 1", imem_req);
    end
  endtask

  task automatic test_plus4();
    int c0;
    c0 = cyc;
    do_instr("plus4_a", 3'd0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 32'h0);
    do_instr("plus4_b", 3'd0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h8, 0, 0, 0, 32'h0);
    do_instr("plus4_c", 3'd0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'hC, 0, 0, 0, 32'h0);
    checks++;
    if (cyc - c0 !== 6) begin
      errors++;
      $display("FAIL throughput: %0d cycles for 3 instr, want 6", cyc - c0);
    end
  endtask

  task automatic test_branch();
    do_instr("jal_100",   3'd1, 3'd0, 0, 0, 0, 32'h100, 0, 0, 32'h0, 32'h100, 1, 0, 0, 32'h0);
    do_instr("bne_taken", 3'd3, 3'b001, 0, 0, 0, 32'h80, 0, 0, 32'h0, 32'h80, 1, 0, 0, 32'h0);
    do_instr("jal_100b",  3'd1, 3'd0, 0, 0, 0, 32'h100, 0, 0, 32'h0, 32'h100, 1, 0, 0, 32'h0);
    do_instr("bne_nt",    3'd3, 3'b001, 1, 0, 0, 32'h80, 0, 0, 32'h0, 32'h104, 0, 0, 0, 32'h0);
    do_instr("bltu_tk",   3'd3, 3'b110, 0, 0, 1, 32'h20, 0, 0, 32'h0, 32'h20, 1, 0, 0, 32'h0);
    do_instr("bge_nt",    3'd3, 3'b101, 0, 1, 0, 32'h80, 0, 0, 32'h0, 32'h24, 0, 0, 0, 32'h0);
    do_instr("f3_undef",  3'd3, 3'b010, 1, 1, 1, 32'h90, 0, 0, 32'h0, 32'h28, 0, 0, 0, 32'h0);
    do_instr("blt_tk",    3'd3, 3'b100, 0, 1, 0, 32'h60, 0, 0, 32'h0, 32'h60, 1, 0, 0, 32'h0);
    do_instr("bgeu_tk",   3'd3, 3'b111, 0, 0, 0, 32'h300, 0, 0, 32'h0, 32'h300, 1, 0, 0, 32'h0);
    do_instr("beq_nt_mis", 3'd3, 3'b000, 0, 0, 0, 32'h302, 0, 0, 32'h0, 32'h304, 0, 0, 0, 32'h0);
  endtask

  task automatic test_jump();
    do_instr("jal_200",   3'd1, 3'd0, 0, 0, 0, 32'h200, 0, 0, 32'h0, 32'h200, 1, 0, 0, 32'h0);
    do_instr("jalr_301",  3'd2, 3'd0, 0, 0, 0, 32'h301, 0, 0, 32'h0, 32'h300, 1, 0, 0, 32'h0);
    do_instr("sel5_plus4", 3'd5, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h304, 0, 0, 0, 32'h0);
    do_instr("jal_200b",  3'd1, 3'd0, 0, 0, 0, 32'h200, 0, 0, 32'h0, 32'h200, 1, 0, 0, 32'h0);
    do_instr("jal_misal", 3'd1, 3'd0, 0, 0, 0, 32'h402, 1, 1, 32'h0, 32'h1000, 0, 1, 1, 32'h200);
  endtask

  task automatic test_interrupt();
    do_instr("jal_3c",    3'd1, 3'd0, 0, 0, 0, 32'h3C, 0, 0, 32'h0, 32'h3C, 1, 0, 0, 32'h200);
    do_instr("intr_masked", 3'd0, 3'd0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h40, 0, 0, 0, 32'h200);
    do_instr("intr_take", 3'd0, 3'd0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 32'h1000, 0, 1, 0, 32'h44);
    do_instr("mret",      3'd4, 3'd0, 0, 0, 0, 32'h0, 1, 1, 32'h44, 32'h44, 1, 0, 0, 32'h44);
    intr_pend = 1'b0;
    intr_en   = 1'b0;
  endtask

  task automatic test_wrap();
    do_instr("jal_top",   3'd1, 3'd0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0, 32'h44);
    do_instr("plus4_wrap", 3'd0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h44);
  endtask

  task automatic test_stall_reset();
    do_instr("jal_500", 3'd1, 3'd0, 0, 0, 0, 32'h500, 0, 0, 32'h0, 32'h500, 1, 0, 0, 32'h44);
    next_sel = 3'd1;
    jal_tgt  = 32'h700;
    commit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, pc} !== {1'b1, 32'h500}) begin
        errors++;
        $display("FAIL stall_%0d: req=%b pc=%h want req=1 pc=00000500", i, imem_req, pc);
      end
    end
    commit = 1'b0;
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    checks++;
    if ({imem_req, pc, mepc_val} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h mval=%h want 0/0/0", imem_req, pc, mepc_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ir_valid, imem_req, pc} !== {2'b01, 32'h0}) begin
      errors++;
      $display("FAIL late_ack: irv=%b req=%b pc=%h want 0/1/00000000", ir_valid, imem_req, pc);
    end
    do_instr("refetch", 3'd0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_plus4();
    test_branch();
    test_jump();
    test_interrupt();
    test_wrap();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
